// File: rtl/plic_gateway_arb.sv
// PLIC gateway and arbiter for hart context 0: level sources become pending bits,
// the best qualifying source is requested from the core, and claim/complete are tracked.
module plic_gateway_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] irq_src,
  input  logic [31:0] cfg_prt,
  input  logic [15:0] cfg_ie,
  input  logic [1:0]  cfg_ith,
  output logic [15:0] plic_ip,
  output logic [3:0]  plic_cpc,
  output logic        core_ex_trap_valid_i,
  output logic [4:0]  core_ex_trap_id_i,
  input  logic        core_ex_trap_ready_o,
  input  logic        core_ex_trap_cplet_o,
  input  logic [4:0]  core_ex_trap_cplet_id_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [15:0] ip_q, ip_d;
  logic [15:0] insvc_q, insvc_d;
  logic        cand_vld_q, cand_vld_d;
  logic [3:0]  cand_id_q, cand_id_d;
  logic [3:0]  req_id_q, req_id_d;
  logic [3:0]  cpc_q, cpc_d;

  logic [15:0] qual;
  logic [1:0]  best_prt;
  logic        claim;
  logic        cmpl;
  logic [15:0] claim_mask;
  logic [15:0] cmpl_mask;
  logic [15:0] gw_set;

  // ip_q[0] is held at zero, so source 0 can never qualify.
  always_comb begin
    qual = '0;
    for (int i = 0; i < 16; i++) begin
      qual[i] = ip_q[i] & cfg_ie[i] & (cfg_prt[2*i +: 2] > cfg_ith);
    end
  end

  // Strict compare while scanning upward keeps the lowest ID on priority ties.
  always_comb begin
    cand_vld_d = 1'b0;
    cand_id_d  = 4'd0;
    best_prt   = 2'd0;
    for (int i = 0; i < 16; i++) begin
      if (qual[i] && (cfg_prt[2*i +: 2] > best_prt)) begin
        best_prt   = cfg_prt[2*i +: 2];
        cand_id_d  = 4'(i);
        cand_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    req_id_d = req_id_q;
    cpc_d    = cpc_q;
    claim    = 1'b0;
    cmpl     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cand_vld_q) begin
          req_id_d = cand_id_q;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (core_ex_trap_ready_o) begin
          claim   = 1'b1;
          cpc_d   = req_id_q;
          state_d = S_ACTIVE;
        end else if (!qual[req_id_q]) begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (core_ex_trap_cplet_o && !core_ex_trap_cplet_id_o[4] &&
            (core_ex_trap_cplet_id_o[3:0] == cpc_q)) begin
          cmpl    = 1'b1;
          cpc_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gateway uses registered in-service, so a source reopens only after completion lands;
  // the claim mask is applied last so a same-cycle claim beats a set.
  always_comb begin
    claim_mask = claim ? (16'd1 << req_id_q) : 16'd0;
    cmpl_mask  = cmpl  ? (16'd1 << cpc_q)    : 16'd0;
    gw_set     = irq_src & ~ip_q & ~insvc_q;
    ip_d       = (ip_q | gw_set) & ~claim_mask & 16'hFFFE;
    insvc_d    = (insvc_q | claim_mask) & ~cmpl_mask & 16'hFFFE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ip_q       <= '0;
      insvc_q    <= '0;
      cand_vld_q <= 1'b0;
      cand_id_q  <= 4'd0;
      req_id_q   <= 4'd0;
      cpc_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      ip_q       <= ip_d;
      insvc_q    <= insvc_d;
      cand_vld_q <= cand_vld_d;
      cand_id_q  <= cand_id_d;
      req_id_q   <= req_id_d;
      cpc_q      <= cpc_d;
    end
  end

  assign plic_ip              = ip_q;
  assign plic_cpc             = cpc_q;
  assign core_ex_trap_valid_i = (state_q == S_REQ);
  assign core_ex_trap_id_i    = (state_q == S_REQ) ? {1'b0, req_id_q} : 5'd0;

endmodule

// File: tb/tb_plic_gateway_arb.sv
// Directed bench for plic_gateway_arb: request latency, arbitration, threshold,
// withdrawal, gateway blocking during service and reset mid-request.
module tb_plic_gateway_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_src;
  logic [31:0] cfg_prt;
  logic [15:0] cfg_ie;
  logic [1:0]  cfg_ith;
  logic [15:0] plic_ip;
  logic [3:0]  plic_cpc;
  logic        valid;
  logic [4:0]  id;
  logic        ready;
  logic        cplet;
  logic [4:0]  cplet_id;

  int checks = 0;
  int errors = 0;

  plic_gateway_arb dut (
    .clk                     (clk),
    .rst                     (rst),
    .irq_src                 (irq_src),
    .cfg_prt                 (cfg_prt),
    .cfg_ie                  (cfg_ie),
    .cfg_ith                 (cfg_ith),
    .plic_ip                 (plic_ip),
    .plic_cpc                (plic_cpc),
    .core_ex_trap_valid_i    (valid),
    .core_ex_trap_id_i       (id),
    .core_ex_trap_ready_o    (ready),
    .core_ex_trap_cplet_o    (cplet),
    .core_ex_trap_cplet_id_o (cplet_id)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    irq_src  = '0;
    cfg_prt  = '0;
    cfg_ie   = '0;
    cfg_ith  = '0;
    ready    = 1'b0;
    cplet    = 1'b0;
    cplet_id = '0;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic set_prt(input int src, input logic [1:0] p);
    cfg_prt[2*src +: 2] = p;
  endtask

  task automatic claim();
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  task automatic complete(input logic [4:0] cid);
    cplet    = 1'b1;
    cplet_id = cid;
    tick(1);
    cplet    = 1'b0;
    cplet_id = '0;
  endtask

  initial begin
    do_reset();
    chk("rst_ip", plic_ip, 16'h0000);
    chk("rst_cpc", 16'(plic_cpc), 16'h0);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_id", 16'(id), 16'h0);

    // Basic flow on source 3
    set_prt(3, 2'd2);
    cfg_ie = 16'h0008;
    irq_src[3] = 1'b1;
    tick(1);
    chk("basic_ip_e0", plic_ip, 16'h0008);
    chk("basic_valid_e0", 16'(valid), 16'h0);
    irq_src[3] = 1'b0;
    tick(1);
    chk("basic_valid_e1", 16'(valid), 16'h0);
    tick(1);
    chk("basic_valid_e2", 16'(valid), 16'h1);
    chk("basic_id_e2", 16'(id), 16'h3);
    claim();
    chk("basic_claim_valid", 16'(valid), 16'h0);
    chk("basic_claim_ip", plic_ip, 16'h0000);
    chk("basic_claim_cpc", 16'(plic_cpc), 16'h3);
    complete(5'd3);
    chk("basic_cmpl_cpc", 16'(plic_cpc), 16'h0);
    claim();
    chk("ready_idle_cpc", 16'(plic_cpc), 16'h0);
    tick(2);
    chk("basic_idle_valid", 16'(valid), 16'h0);

    // Priority and tie-break: 5 (prt1), 7 (prt3), 9 (prt3)
    do_reset();
    set_prt(5, 2'd1);
    set_prt(7, 2'd3);
    set_prt(9, 2'd3);
    cfg_ie  = 16'h02A0;
    irq_src = 16'h02A0;
    tick(1);
    irq_src = '0;
    tick(2);
    chk("prio_ip", plic_ip, 16'h02A0);
    chk("prio_valid_7", 16'(valid), 16'h1);
    chk("prio_id_7", 16'(id), 16'h7);
    claim();
    chk("prio_cpc_7", 16'(plic_cpc), 16'h7);
    complete(5'd7);
    chk("prio_after7_valid", 16'(valid), 16'h0);
    tick(1);
    chk("prio_valid_9", 16'(valid), 16'h1);
    chk("prio_id_9", 16'(id), 16'h9);
    claim();
    complete(5'd9);
    tick(1);
    chk("prio_id_5", 16'(id), 16'h5);
    claim();
    chk("prio_cpc_5", 16'(plic_cpc), 16'h5);
    complete(5'd5);
    tick(2);
    chk("prio_done_valid", 16'(valid), 16'h0);
    chk("prio_done_ip", plic_ip, 16'h0000);

    // Threshold 2 and reserved source 0
    do_reset();
    cfg_ith = 2'd2;
    set_prt(0, 2'd3);
    set_prt(4, 2'd2);
    set_prt(6, 2'd3);
    cfg_ie  = 16'h0051;
    irq_src = 16'h0051;
    tick(1);
    irq_src = 16'h0001;
    tick(2);
    chk("thr_ip", plic_ip, 16'h0050);
    chk("thr_id_6", 16'(id), 16'h6);
    claim();
    complete(5'd6);
    tick(4);
    chk("thr_no_req_valid", 16'(valid), 16'h0);
    chk("thr_ip_left", plic_ip, 16'h0010);

    // Withdrawal of source 2
    do_reset();
    set_prt(2, 2'd1);
    cfg_ie = 16'h0004;
    irq_src[2] = 1'b1;
    tick(1);
    irq_src[2] = 1'b0;
    tick(2);
    chk("wd_valid", 16'(valid), 16'h1);
    chk("wd_id", 16'(id), 16'h2);
    complete(5'd2);
    chk("wd_cplet_in_req_valid", 16'(valid), 16'h1);
    chk("wd_cplet_in_req_cpc", 16'(plic_cpc), 16'h0);
    cfg_ie = 16'h0000;
    tick(1);
    chk("wd_withdrawn_valid", 16'(valid), 16'h0);
    chk("wd_ip_kept", plic_ip, 16'h0004);
    tick(2);
    chk("wd_stays_idle", 16'(valid), 16'h0);
    cfg_ie = 16'h0004;
    tick(1);
    chk("wd_reen_e1", 16'(valid), 16'h0);
    tick(1);
    chk("wd_reen_valid", 16'(valid), 16'h1);
    chk("wd_reen_id", 16'(id), 16'h2);

    // Gateway blocked while source 8 is in service
    do_reset();
    set_prt(8, 2'd2);
    cfg_ie = 16'h0100;
    irq_src[8] = 1'b1;
    tick(3);
    chk("gw_id_8", 16'(id), 16'h8);
    claim();
    chk("gw_claim_ip", plic_ip, 16'h0000);
    chk("gw_claim_cpc", 16'(plic_cpc), 16'h8);
    tick(2);
    chk("gw_held_ip", plic_ip, 16'h0000);
    complete(5'd9);
    chk("gw_wrong_id_cpc", 16'(plic_cpc), 16'h8);
    complete(5'h18);
    chk("gw_bit4_cpc", 16'(plic_cpc), 16'h8);
    chk("gw_bit4_ip", plic_ip, 16'h0000);
    complete(5'd8);
    chk("gw_cmpl_cpc", 16'(plic_cpc), 16'h0);
    chk("gw_cmpl_ip", plic_ip, 16'h0000);
    tick(1);
    chk("gw_reopen_ip", plic_ip, 16'h0100);
    tick(1);
    chk("gw_rereq_e2", 16'(valid), 16'h0);
    tick(1);
    chk("gw_rereq_valid", 16'(valid), 16'h1);
    chk("gw_rereq_id", 16'(id), 16'h8);

    // Reset while in REQ with the source still high
    rst = 1'b1;
    tick(1);
    chk("midrst_valid", 16'(valid), 16'h0);
    chk("midrst_ip", plic_ip, 16'h0000);
    chk("midrst_cpc", 16'(plic_cpc), 16'h0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
